// File: rtl/me_search_buffer.sv
// me_search_buffer: stores one macroblock and its search window in banked RAM and serves me with rotated rows
// Ports: clk, rst (async, active-high); start begins a load of the pix_in/pix_valid/pix_ready raster stream;
//        addr/amt select a read whose data appears on pixel_cpr_out/pixel_spr_out one cycle later;
//        me_start pulses once both pictures are stored, buf_ready holds until me_done releases the buffer.
module me_search_buffer #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int PORT_WIDTH = MACRO_DIM + 1,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [4:0]              amt,
    output logic [8*MACRO_DIM-1:0]  pixel_cpr_out,
    output logic [8*PORT_WIDTH-1:0] pixel_spr_out,
    output logic                    me_start,
    input  logic                    me_done,
    output logic                    buf_ready
);
    localparam int NGRP  = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
    localparam int DEPTH = NGRP * SEARCH_DIM;
    localparam int MW    = $clog2(MACRO_DIM);
    localparam int CW    = $clog2(SEARCH_DIM);
    localparam int BW    = $clog2(PORT_WIDTH);
    localparam int GW    = NGRP > 1 ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_CUR, LOAD_SRCH, READY} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           row_q, row_d, col_q, col_d;
    logic [BW-1:0]           bank_q, bank_d;
    logic [GW-1:0]           grp_q, grp_d;
    logic                    pix_ready_q, me_start_q, buf_ready_q;
    logic [8*MACRO_DIM-1:0]  cpr_q, cpr_d;
    logic [8*PORT_WIDTH-1:0] spr_q, spr_d;
    logic [7:0]              cur_bank [MACRO_DIM][MACRO_DIM];
    logic [7:0]              srch_bank [PORT_WIDTH][DEPTH];
    logic                    accept, col_end, row_end;
    logic [ADDR_W-1:0]       waddr;

    function automatic logic [BW-1:0] rot(input int lane, input logic [4:0] a);
        int s;
        s = lane + int'(a);
        return BW'(s >= PORT_WIDTH ? s - PORT_WIDTH : s);
    endfunction

    always_comb begin
        accept  = pix_valid && pix_ready_q;
        // One row/col counter pair walks both pictures; only the wrap limits differ.
        col_end = state_q == LOAD_CUR ? col_q == CW'(MACRO_DIM - 1) : col_q == CW'(SEARCH_DIM - 1);
        row_end = state_q == LOAD_CUR ? row_q == CW'(MACRO_DIM - 1) : row_q == CW'(SEARCH_DIM - 1);
        waddr   = ADDR_W'(grp_q) * ADDR_W'(SEARCH_DIM) + ADDR_W'(row_q);
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        bank_d  = bank_q;
        grp_d   = grp_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_CUR;
                row_d   = '0;
                col_d   = '0;
                bank_d  = '0;
                grp_d   = '0;
            end
            LOAD_CUR, LOAD_SRCH: if (accept) begin
                col_d  = col_end ? '0 : col_q + 1'b1;
                row_d  = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
                // bank is column mod PORT_WIDTH and grp is column div PORT_WIDTH, both restarting each row
                bank_d = col_end || bank_q == BW'(PORT_WIDTH - 1) ? '0 : bank_q + 1'b1;
                grp_d  = col_end ? '0 : bank_q == BW'(PORT_WIDTH - 1) ? grp_q + 1'b1 : grp_q;
                if (col_end && row_end) state_d = state_q == LOAD_CUR ? LOAD_SRCH : READY;
            end
            READY: if (me_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpr_d = '0;
        spr_d = '0;
        for (int i = 0; i < MACRO_DIM; i++) cpr_d[8*i +: 8] = cur_bank[i][addr[MW-1:0]];
        for (int i = 0; i < PORT_WIDTH; i++)
            if (int'(amt) <= MACRO_DIM && int'(addr) < DEPTH) spr_d[8*i +: 8] = srch_bank[rot(i, amt)][addr];
    end

    // Memories are never reset; nonblocking writes give read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (accept && state_q == LOAD_CUR) cur_bank[col_q[MW-1:0]][row_q[MW-1:0]] <= pix_in;
        if (accept && state_q == LOAD_SRCH) srch_bank[bank_q][waddr] <= pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            bank_q      <= '0;
            grp_q       <= '0;
            pix_ready_q <= 1'b0;
            me_start_q  <= 1'b0;
            buf_ready_q <= 1'b0;
            cpr_q       <= '0;
            spr_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bank_q      <= bank_d;
            grp_q       <= grp_d;
            pix_ready_q <= state_d == LOAD_CUR || state_d == LOAD_SRCH;
            me_start_q  <= state_q == LOAD_SRCH && state_d == READY;
            buf_ready_q <= state_d == READY;
            cpr_q       <= cpr_d;
            spr_q       <= spr_d;
        end
    end

    assign pix_ready     = pix_ready_q;
    assign me_start      = me_start_q;
    assign buf_ready     = buf_ready_q;
    assign pixel_cpr_out = cpr_q;
    assign pixel_spr_out = spr_q;
endmodule
